// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern table, bit order and scan FSM states
package seg7_pkg;

    // Segment bit positions within the 7-bit bus (bit0 = a ... bit6 = g)
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = 7;

    // Active-low pattern with every segment dark
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs for nibbles 0..F, entry [n] is the glyph of nibble n
    localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } scan_state_e;

    // Encoder-side lookup, kept beside the table so both directions share it
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nibble);
        return SEG_PATTERNS[nibble];
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational seven-segment pattern to nibble decoder
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic             legal_o,
    output logic             blank_o,
    output logic [3:0]       nibble_o
);

    // Reverse lookup of the glyph table; the glyphs are unique so at most one entry matches
    always_comb begin
        legal_o  = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_PATTERNS[i]) begin
                legal_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
        blank_o = (pattern_i == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced readback of a multiplexed active-low seven-segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    update,
    output logic                    err_pattern,
    output logic [2:0]              err_digit
);

    localparam logic [7:0] STABLE_CNT8 = 8'(STABLE_COUNT);

    // Sampled bus (s_q) and the sample before it, which is the value being debounced
    logic [SEG_W-1:0]      seg_q, seg_p_q;
    logic                  dp_q, dp_p_q;
    logic [NUM_DIGITS-1:0] an_q, an_p_q;

    logic [7:0]  cnt_q, cnt_d;
    scan_state_e state_q, state_d;

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    frame_q, update_q;
    logic                    err_q, err_d;
    logic [2:0]              err_digit_q, err_digit_d;

    logic       one_hot;
    logic       changed;
    logic       pat_legal, pat_blank;
    logic [3:0] pat_nibble;

    // The committed value is always the previous sample, which matched for cnt samples in a row
    seg7_pattern_decode u_decode (
        .pattern_i (seg_p_q),
        .legal_o   (pat_legal),
        .blank_o   (pat_blank),
        .nibble_o  (pat_nibble)
    );

    assign one_hot = $onehot(~an_q);
    assign changed = ({seg_q, dp_q, an_q} != {seg_p_q, dp_p_q, an_p_q});

    // Consecutive-identical-sample counter, cleared while no single digit is selected
    always_comb begin
        cnt_d = cnt_q;
        if (!one_hot) begin
            cnt_d = 8'd0;
        end else if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Input sampling, counter and FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= '1;
            seg_p_q <= SEG_BLANK;
            dp_p_q  <= 1'b1;
            an_p_q  <= '1;
            cnt_q   <= 8'd0;
            state_q <= ST_IDLE;
        end else begin
            seg_q   <= seg_in;
            dp_q    <= dp_in;
            an_q    <= an_in;
            seg_p_q <= seg_q;
            dp_p_q  <= dp_q;
            an_p_q  <= an_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next state; a change seen during COMMIT restarts tracking so that sample is not lost
    always_comb begin
        state_d = state_q;
        if (!one_hot) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_TRACK;
                ST_TRACK:  state_d = (cnt_d == STABLE_CNT8) ? ST_COMMIT : ST_TRACK;
                ST_COMMIT: state_d = changed ? ST_TRACK : ST_HOLD;
                ST_HOLD:   state_d = changed ? ST_TRACK : ST_HOLD;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Per-digit storage and sticky error updates applied in the COMMIT cycle
    always_comb begin
        hex_d       = hex_q;
        dp_out_d    = dp_out_q;
        valid_d     = valid_q;
        err_d       = err_q;
        err_digit_d = err_digit_q;
        if (err_clr) begin
            err_d       = 1'b0;
            err_digit_d = 3'd0;
        end
        if (state_q == ST_COMMIT) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (!an_p_q[d]) begin
                    if (pat_legal) begin
                        hex_d[4*d +: 4] = pat_nibble;
                        dp_out_d[d]     = ~dp_p_q;
                        valid_d[d]      = 1'b1;
                    end else if (pat_blank) begin
                        dp_out_d[d]     = ~dp_p_q;
                        valid_d[d]      = 1'b0;
                    end else begin
                        valid_d[d]      = 1'b0;
                        if (!err_q || err_clr) begin
                            err_d       = 1'b1;
                            err_digit_d = 3'(d);
                        end
                    end
                end
            end
        end
    end

    // Output registers; frame_valid follows the next digit_valid so both rise together
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q       <= '0;
            dp_out_q    <= '0;
            valid_q     <= '0;
            frame_q     <= 1'b0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 3'd0;
        end else begin
            hex_q       <= hex_d;
            dp_out_q    <= dp_out_d;
            valid_q     <= valid_d;
            frame_q     <= &valid_d;
            update_q    <= (state_q == ST_COMMIT);
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign hex_out     = hex_q;
    assign dp_out      = dp_out_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign update      = update_q;
    assign err_pattern = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam logic [6:0] P1    = 7'b1111001;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P5    = 7'b0010010;
    localparam logic [6:0] P8    = 7'b0000000;
    localparam logic [6:0] PA    = 7'b0001000;
    localparam logic [6:0] PC    = 7'b1000110;
    localparam logic [6:0] PF    = 7'b0001110;
    localparam logic [6:0] PGLT  = 7'b0110001;
    localparam logic [6:0] PBAD  = 7'b1010101;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = BLANK;
    logic        dp_in = 1'b1;
    logic [3:0]  an_in = 4'b1111;
    logic        err_clr = 1'b0;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        update;
    logic        err_pattern;
    logic [2:0]  err_digit;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int base;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_COUNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .an_in       (an_in),
        .err_clr     (err_clr),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .update      (update),
        .err_pattern (err_pattern),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        upd_cnt += int'(update);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
        an_in  = an;
        seg_in = seg;
        dp_in  = dp;
    endtask

    task automatic idle(input int n);
        drive(4'b1111, BLANK, 1'b1);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (hex_out !== 16'h0000) begin errors++; $display("FAIL reset_hex: got %h expected 0000", hex_out); end
        checks++; if (dp_out !== 4'b0000) begin errors++; $display("FAIL reset_dp: got %b expected 0000", dp_out); end
        checks++; if (digit_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", digit_valid); end
        checks++; if ({frame_valid, update, err_pattern} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {frame_valid, update, err_pattern}); end
        checks++; if (err_digit !== 3'd0) begin errors++; $display("FAIL reset_err_digit: got %0d expected 0", err_digit); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        base = upd_cnt;
        drive(4'b1110, P2, 1'b1);
        repeat (5) tick();
        checks++; if ({digit_valid, update} !== 5'b00000) begin errors++; $display("FAIL single_early: got valid=%b update=%b expected 0000/0", digit_valid, update); end
        tick();
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL single_update: got %b expected 1", update); end
        checks++; if (hex_out !== 16'h0002) begin errors++; $display("FAIL single_hex: got %h expected 0002", hex_out); end
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b expected 0001", digit_valid); end
        repeat (4) tick();
        checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", upd_cnt - base); end
    endtask

    task automatic test_scan();
        logic [3:0] an_tab [4];
        logic [6:0] pat_tab [4];
        logic       dp_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        pat_tab = '{P1, PA, PC, PF};
        dp_tab  = '{1'b1, 1'b1, 1'b0, 1'b1};
        idle(2);
        base = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(an_tab[i], pat_tab[i], dp_tab[i]);
            repeat (6) tick();
            if (i == 2) begin
                checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL scan_frame_early: got %b expected 0", frame_valid); end
            end
        end
        checks++; if (hex_out !== 16'hFCA1) begin errors++; $display("FAIL scan_hex: got %h expected fca1", hex_out); end
        checks++; if (digit_valid !== 4'b1111) begin errors++; $display("FAIL scan_valid: got %b expected 1111", digit_valid); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL scan_frame: got %b expected 1", frame_valid); end
        checks++; if (dp_out !== 4'b0100) begin errors++; $display("FAIL scan_dp: got %b expected 0100", dp_out); end
        checks++; if (upd_cnt - base !== 4) begin errors++; $display("FAIL scan_pulses: got %0d expected 4", upd_cnt - base); end
    endtask

    task automatic test_glitch();
        idle(2);
        drive(4'b1110, P3, 1'b1);
        repeat (6) tick();
        checks++; if (hex_out !== 16'hFCA3) begin errors++; $display("FAIL glitch_base_hex: got %h expected fca3", hex_out); end
        base = upd_cnt;
        drive(4'b1110, PGLT, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (update !== 1'b0 || hex_out !== 16'hFCA3) begin errors++; $display("FAIL glitch_burst: got update=%b hex=%h expected 0/fca3", update, hex_out); end
        end
        drive(4'b1110, P3, 1'b1);
        repeat (10) tick();
        checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL glitch_recommit: got %0d expected 1", upd_cnt - base); end
        checks++; if (hex_out !== 16'hFCA3 || digit_valid !== 4'b1111) begin errors++; $display("FAIL glitch_after: got hex=%h valid=%b expected fca3/1111", hex_out, digit_valid); end
    endtask

    task automatic test_error();
        idle(2);
        drive(4'b1011, PBAD, 1'b1);
        repeat (6) tick();
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL err_update: got %b expected 1", update); end
        checks++; if (err_pattern !== 1'b1 || err_digit !== 3'd2) begin errors++; $display("FAIL err_first: got err=%b digit=%0d expected 1/2", err_pattern, err_digit); end
        checks++; if (digit_valid !== 4'b1011 || frame_valid !== 1'b0) begin errors++; $display("FAIL err_valid: got valid=%b frame=%b expected 1011/0", digit_valid, frame_valid); end
        checks++; if (hex_out !== 16'hFCA3 || dp_out !== 4'b0100) begin errors++; $display("FAIL err_hold: got hex=%h dp=%b expected fca3/0100", hex_out, dp_out); end
        idle(2);
        drive(4'b0111, PBAD, 1'b1);
        repeat (6) tick();
        checks++; if (err_digit !== 3'd2 || digit_valid !== 4'b0011) begin errors++; $display("FAIL err_sticky: got digit=%0d valid=%b expected 2/0011", err_digit, digit_valid); end
        idle(2);
        drive(4'b1101, PBAD, 1'b1);
        repeat (5) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_pattern !== 1'b1 || err_digit !== 3'd1) begin errors++; $display("FAIL err_clr_race: got err=%b digit=%0d expected 1/1", err_pattern, err_digit); end
        checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL err_clr_valid: got %b expected 0001", digit_valid); end
        idle(2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_pattern !== 1'b0 || err_digit !== 3'd0) begin errors++; $display("FAIL err_clear: got err=%b digit=%0d expected 0/0", err_pattern, err_digit); end
    endtask

    task automatic test_blank();
        idle(2);
        drive(4'b1011, BLANK, 1'b1);
        repeat (6) tick();
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL blank_update: got %b expected 1", update); end
        checks++; if (dp_out !== 4'b0000 || digit_valid !== 4'b0001) begin errors++; $display("FAIL blank_dp_valid: got dp=%b valid=%b expected 0000/0001", dp_out, digit_valid); end
        checks++; if (hex_out !== 16'hFCA3) begin errors++; $display("FAIL blank_hex: got %h expected fca3", hex_out); end
    endtask

    task automatic test_bad_anode();
        idle(2);
        base = upd_cnt;
        drive(4'b1100, P8, 1'b0);
        repeat (10) tick();
        drive(4'b1111, P8, 1'b0);
        repeat (10) tick();
        checks++; if (upd_cnt - base !== 0) begin errors++; $display("FAIL anode_pulses: got %0d expected 0", upd_cnt - base); end
        checks++; if (hex_out !== 16'hFCA3 || digit_valid !== 4'b0001 || dp_out !== 4'b0000) begin errors++; $display("FAIL anode_outputs: got hex=%h valid=%b dp=%b expected fca3/0001/0000", hex_out, digit_valid, dp_out); end
        checks++; if (frame_valid !== 1'b0 || err_pattern !== 1'b0) begin errors++; $display("FAIL anode_flags: got frame=%b err=%b expected 0/0", frame_valid, err_pattern); end
    endtask

    task automatic test_reset_midcount();
        idle(2);
        drive(4'b1101, P5, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++; if (hex_out !== 16'h0000 || dp_out !== 4'b0000 || digit_valid !== 4'b0000) begin errors++; $display("FAIL midrst_data: got hex=%h dp=%b valid=%b expected 0000/0000/0000", hex_out, dp_out, digit_valid); end
        checks++; if ({frame_valid, update, err_pattern, err_digit} !== 6'b000000) begin errors++; $display("FAIL midrst_flags: got %b expected 000000", {frame_valid, update, err_pattern, err_digit}); end
        drive(4'b1111, BLANK, 1'b1);
        tick();
        rst = 1'b0;
        base = upd_cnt;
        repeat (10) tick();
        checks++; if (upd_cnt - base !== 0 || digit_valid !== 4'b0000) begin errors++; $display("FAIL midrst_after: got pulses=%0d valid=%b expected 0/0000", upd_cnt - base, digit_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_glitch();
        test_error();
        test_blank();
        test_bad_anode();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
